// File: rtl/dyn_shift_reg_mw.sv
// Multi-bit, bidirectional shift register with parallel load, per-stage valid
// tracking and a registered run-time selectable tap.
module dyn_shift_reg_mw #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SELWIDTH = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clken,
  input  logic                            clr,
  input  logic                            dir,
  input  logic                            load,
  input  logic [(2**SELWIDTH)*WIDTH-1:0]  pdata,
  input  logic [WIDTH-1:0]                si,
  input  logic                            si_valid,
  input  logic [SELWIDTH-1:0]             sel,
  output logic [WIDTH-1:0]                dout,
  output logic                            dout_valid,
  output logic                            full,
  output logic                            empty
);

  localparam int unsigned DEPTH = 2 ** SELWIDTH;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    vld_d = vld_q;
    if (clken) begin
      if (load) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          data_d[i] = pdata[i*WIDTH +: WIDTH];
        end
        vld_d = '1;
      end else if (!dir) begin
        data_d[0] = si;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          data_d[i] = data_q[i-1];
        end
        vld_d = {vld_q[DEPTH-2:0], si_valid};
      end else begin
        data_d[DEPTH-1] = si;
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          data_d[i] = data_q[i+1];
        end
        vld_d = {si_valid, vld_q[DEPTH-1:1]};
      end
    end
  end

  // Tap register samples the pre-edge stage contents, independent of clken.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      vld_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      vld_q        <= vld_d;
      dout_q       <= data_q[sel];
      dout_valid_q <= vld_q[sel];
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign full       = &vld_q;
  assign empty      = ~|vld_q;

endmodule

// File: tb/tb_dyn_shift_reg_mw.sv
// Randomised and directed bench for dyn_shift_reg_mw against a queue-based model.
module tb_dyn_shift_reg_mw;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned SELWIDTH = 3;
  localparam int unsigned DEPTH    = 2 ** SELWIDTH;

  logic                     clk = 1'b0;
  logic                     rst_n, clken, clr, dir, load, si_valid;
  logic [DEPTH*WIDTH-1:0]   pdata;
  logic [WIDTH-1:0]         si;
  logic [SELWIDTH-1:0]      sel;
  logic [WIDTH-1:0]         dout;
  logic                     dout_valid, full, empty;

  int n_checks = 0;
  int n_errors = 0;

  // Model: queue of {valid, word}; element i is stage i.
  logic [WIDTH:0]   mq [$];
  logic [WIDTH-1:0] m_dout;
  logic             m_dv;

  always #5 clk = ~clk;

  dyn_shift_reg_mw #(
    .WIDTH    (WIDTH),
    .SELWIDTH (SELWIDTH)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clken      (clken),
    .clr        (clr),
    .dir        (dir),
    .load       (load),
    .pdata      (pdata),
    .si         (si),
    .si_valid   (si_valid),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full),
    .empty      (empty)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back('0);
    m_dout = '0;
    m_dv   = 1'b0;
  endfunction

  function automatic void model_step();
    logic [WIDTH:0] tap;
    if (!rst_n || clr) begin
      model_clear();
      return;
    end
    tap = mq[sel];
    if (clken) begin
      if (load) begin
        for (int i = 0; i < DEPTH; i++) mq[i] = {1'b1, pdata[i*WIDTH +: WIDTH]};
      end else if (!dir) begin
        mq.push_front({si_valid, si});
        void'(mq.pop_back());
      end else begin
        mq.push_back({si_valid, si});
        void'(mq.pop_front());
      end
    end
    m_dout = tap[WIDTH-1:0];
    m_dv   = tap[WIDTH];
  endfunction

  function automatic logic model_full();
    foreach (mq[i]) if (!mq[i][WIDTH]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic model_empty();
    foreach (mq[i]) if (mq[i][WIDTH]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_val("dout", 32'(dout), 32'(m_dout));
    check_val("dout_valid", 32'(dout_valid), 32'(m_dv));
    check_val("full", 32'(full), 32'(model_full()));
    check_val("empty", 32'(empty), 32'(model_empty()));
  endtask

  task automatic idle_inputs();
    clken = 1'b0; clr = 1'b0; dir = 1'b0; load = 1'b0;
    si = '0; si_valid = 1'b0; pdata = '0;
  endtask

  initial begin
    model_clear();
    idle_inputs();
    sel   = '0;
    rst_n = 1'b0;
    cycle();
    cycle();
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;

    // Fill forward, tap at stage 3.
    clken = 1'b1; sel = 3'd3; si_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      si = 8'(i + 1);
      cycle();
      if (i == 0) check_val("empty_after_first", 32'(empty), 32'd0);
      if (i == 4) begin
        check_val("tap3_data", 32'(dout), 32'h01);
        check_val("tap3_valid", 32'(dout_valid), 32'd1);
      end
    end
    check_val("full_after_8", 32'(full), 32'd1);

    // Parallel load, then sweep taps while stalled.
    load = 1'b1;
    for (int i = 0; i < DEPTH; i++) pdata[i*WIDTH +: WIDTH] = 8'(8'hA0 + i);
    cycle();
    load = 1'b0; clken = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      sel = 3'(s);
      cycle();
      check_val("load_sweep", 32'(dout), 32'(8'hA0 + s));
      check_val("load_sweep_v", 32'(dout_valid), 32'd1);
    end

    // Reverse shift of one invalid word.
    clken = 1'b1; dir = 1'b1; si = 8'h55; si_valid = 1'b0;
    cycle();
    clken = 1'b0; sel = 3'd7;
    cycle();
    check_val("rev_tap7", 32'(dout), 32'h55);
    check_val("rev_tap7_v", 32'(dout_valid), 32'd0);
    check_val("rev_full", 32'(full), 32'd0);
    sel = 3'd6;
    cycle();
    check_val("rev_tap6", 32'(dout), 32'hA7);

    // Stream with clken toggling.
    dir = 1'b0; sel = 3'd2;
    for (int i = 0; i < 16; i++) begin
      clken = (i % 2 == 0); si = 8'(8'h10 + i); si_valid = 1'b1;
      cycle();
    end

    // clr beats load.
    clken = 1'b1; clr = 1'b1; load = 1'b1; pdata = '1;
    cycle();
    check_val("clr_dout", 32'(dout), 32'd0);
    check_val("clr_empty", 32'(empty), 32'd1);
    clr = 1'b0; load = 1'b0;
    cycle();
    check_val("clr_dout2", 32'(dout), 32'd0);

    // Reset mid-stream.
    si = 8'h77; si_valid = 1'b1;
    cycle(); cycle();
    rst_n = 1'b0;
    cycle();
    check_val("midrst_empty", 32'(empty), 32'd1);
    check_val("midrst_dv", 32'(dout_valid), 32'd0);
    rst_n = 1'b1; sel = 3'd0;
    cycle(); cycle();
    check_val("refill_tap0", 32'(dout), 32'h77);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      clr      = ($urandom_range(0, 49) == 0);
      clken    = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 15) == 0);
      dir      = 1'($urandom);
      si       = 8'($urandom);
      si_valid = 1'($urandom);
      sel      = 3'($urandom);
      for (int w = 0; w < DEPTH; w++) pdata[w*WIDTH +: WIDTH] = 8'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dyn_shift_reg_mw.md
# dyn_shift_reg_mw

Multi-bit, bidirectional, variable-tap shift register with parallel load, per-stage valid tracking and a registered tap output. Successor to the single-bit dynamic shift register: generalises word width and depth, adds direction control, parallel load, clear and occupancy flags. Used as a programmable delay line / tap buffer in datapaths where the delay is selected at run time and the consumer must know whether the tapped word is real data.

## Interface
- WIDTH, 8, word width in bits (≥1)
- SELWIDTH, 3, tap-select width; DEPTH = 2**SELWIDTH stages (localparam, DEPTH ≥ 2)

- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  synchronous reset, active-low
- clken  input  1  stage enable; shift/load occur only when high
- clr  input  1  synchronous clear of all stages and valids (independent of clken)
- dir  input  1  0: shift toward higher index, si enters stage 0; 1: shift toward lower index, si enters stage DEPTH-1
- load  input  1  with clken, parallel-load all stages from pdata
- pdata  input  DEPTH*WIDTH  parallel data; stage i = pdata[i*WIDTH +: WIDTH]
- si  input  WIDTH  serial input word
- si_valid  input  1  valid bit shifted in with si
- sel  input  SELWIDTH  tap index
- dout  output  WIDTH  registered word from stage sel
- dout_valid  output  1  registered valid bit of stage sel
- full  output  1  all stage valids set (combinational from state)
- empty  output  1  no stage valid set (combinational from state)

## Operation
- State: data[0..DEPTH-1] (WIDTH bits each), vld[0..DEPTH-1].
- Per-edge priority, highest first:
  - rst_n=0: data, vld, dout, dout_valid ← 0.
  - clr=1: data, vld ← 0; dout, dout_valid ← 0.
  - clken=1, load=1: data[i] ← pdata slice i; vld ← all ones (si, si_valid, dir ignored).
  - clken=1, load=0, dir=0: data[0] ← si, data[i] ← data[i-1]; vld likewise with si_valid; stage DEPTH-1 discarded.
  - clken=1, load=0, dir=1: data[DEPTH-1] ← si, data[i] ← data[i+1]; vld likewise; stage 0 discarded.
  - clken=0: data, vld hold.
- Output register (every edge unless reset/clr): dout ← data[sel], dout_valid ← vld[sel], using pre-edge state (old contents, not this edge's shift/load result).
- dout updates regardless of clken, so sel changes are reflected while stalled.
- full = &vld, empty = ~|vld; reset values: full=0, empty=1.
- Direction may change on any cycle; no internal state reordering, vld tracks each word so bubbles are reported correctly.
- sel is always in range (DEPTH = 2**SELWIDTH); no out-of-range case.

## Timing
- Reset and clr take effect at the edge they are sampled; outputs 0 after that edge.
- Tap latency, dir=0, clken held high: si sampled at edge n is in stage k after edge n+k; visible on dout (sel=k) after edge n+k+1. Total delay k+2 edges from si to dout, equivalently k+1 cycles after first edge.
- dir=1: same with stage index replaced by DEPTH-1-k.
- sel change to dout: 1 edge.
- load at edge n: dout reflects pdata slice sel after edge n+1, dout_valid=1.
- clken low stalls stages; dout keeps tracking current stage sel.
- clr and load same edge: clr wins. rst_n low overrides all.
- Reset mid-shift: all in-flight words and valids lost; no partial state.

## Test plan
- WIDTH=8, SELWIDTH=3. Reset, then dir=0, clken=1, si=0x01..0x08 with si_valid=1 on consecutive edges, sel=3 -> dout=0x01, dout_valid=1 five edges after 0x01 sampled; full=1 after eighth shift, empty=0 after first.
- load=1, pdata stage i = 0xA0+i, then sel sweeps 0..7 with clken=0 -> dout = 0xA0..0xA7 one edge after each sel, dout_valid=1, full=1.
- After load, dir=1, shift in si=0x55 si_valid=0 once -> stage 7 = 0x55, vld[7]=0; sel=7 gives dout=0x55, dout_valid=0; sel=6 gives 0xA7; full=0.
- Stream with clken toggling 1,0,1,0 -> stages move only on clken=1 edges; tap delay in edges doubles accordingly, no word duplicated or lost.
- Mid-stream assert clr together with load -> all stages 0, dout=0, dout_valid=0, empty=1; pdata ignored.
- Drive rst_n=0 for one edge mid-stream with clken=1 -> dout=0, dout_valid=0, empty=1 next edge; resume shifting refills from stage 0.
